// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared types and constants for the BRAM stream reader
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stream_state_t;

  localparam int FIFO_DEPTH  = 4;
  // A read may only be issued while buffered plus in-flight words stay below this,
  // so the word returned next cycle always has a free FIFO slot.
  localparam int ISSUE_LIMIT = FIFO_DEPTH;
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with exposed occupancy count and head
module sync_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_WIDTH'(1);
        2'b01:   count <= count - COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - turns a (base, count) command into a BRAM read word stream
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int BRAM_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_SIZE  = 4,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [BRAM_WIDTH-1:0] bram_rddata,
  output logic [BRAM_WIDTH-1:0] bram_wrdata,
  output logic [WORD_SIZE-1:0]  bram_we,
  output logic [BRAM_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(WORD_SIZE);
  localparam int                    SUM_W      = COUNT_WIDTH + 1;

  stream_state_t          state;
  logic [LEN_WIDTH-1:0]   remaining;
  logic                   inflight;
  logic [COUNT_WIDTH-1:0] fifo_count;
  logic [SUM_W-1:0]       occupancy;
  logic                   issue;
  logic                   pop;
  logic                   last_pop;

  assign bram_we     = '0;
  assign bram_wrdata = '0;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign occupancy = SUM_W'(fifo_count) + SUM_W'(inflight);
  // bram_addr always holds the next address to read; issuing means the BRAM samples it this cycle.
  assign issue     = (state == RUN) && (occupancy < SUM_W'(ISSUE_LIMIT));
  // In DRAIN nothing new is issued, so an empty pipe behind the head means this is the final word.
  assign last_pop  = (state == DRAIN) && pop && !inflight && (fifo_count == COUNT_WIDTH'(1));

  sync_fifo #(
    .WIDTH       (BRAM_WIDTH),
    .DEPTH       (FIFO_DEPTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (bram_rddata),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

  // Command FSM with address/remaining counters and the one-cycle read-latency tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bram_addr <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              bram_addr <= base_addr & ALIGN_MASK;
              remaining <= num_words;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            bram_addr <= bram_addr + ADDR_STEP;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed table-driven bench for bram_stream_reader
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [10:0] num_words;
  logic        busy;
  logic        done;
  logic [11:0] bram_addr;
  logic [31:0] bram_rddata;
  logic [31:0] bram_wrdata;
  logic [3:0]  bram_we;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  bram_stream_reader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .busy        (busy),
    .done        (done),
    .bram_addr   (bram_addr),
    .bram_rddata (bram_rddata),
    .bram_wrdata (bram_wrdata),
    .bram_we     (bram_we),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always @(posedge clk) bram_rddata <= mem[bram_addr[11:2]];

  function automatic logic [31:0] mem_val(input int i);
    return 32'hA500_0000 + 32'(i) * 32'd7 + 32'd1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] base;
    int          num;
    logic [7:0]  pat;
    int          first_idx;
    int          hold;
    int          restart_k;
  } vec_t;

  task automatic run_cmd(input string tag, input vec_t v);
    int          k;
    int          got;
    int          first_k;
    int          last_k;
    int          done_k;
    int          stall_bad;
    int          side_bad;
    logic        stalled;
    logic [31:0] held;
    logic [11:0] frozen;
    frozen = v.base + 12'd16;
    @(negedge clk);
    start     = 1'b1;
    base_addr = v.base;
    num_words = 11'(v.num);
    out_ready = (v.hold > 0) ? 1'b0 : v.pat[0];
    @(negedge clk);
    start = 1'b0;
    k = 1; got = 0; first_k = -1; last_k = -1; done_k = -1;
    stall_bad = 0; side_bad = 0; stalled = 1'b0; held = '0;
    if (v.num > 0) check({tag, " busy_after_start"}, 64'(busy), 64'(1));
    while (k < 300) begin
      if (stalled && (out_data !== held || !out_valid)) stall_bad++;
      if (bram_we !== 4'd0 || bram_wrdata !== 32'd0) side_bad++;
      if (out_valid && first_k < 0) first_k = k;
      if (v.hold > 0 && (k == 6 || k == v.hold))
        check({tag, " frozen_addr"}, 64'(bram_addr), 64'(frozen));
      if (done) begin
        done_k = k;
        break;
      end
      start = (k == v.restart_k);
      if (k == v.restart_k) begin
        base_addr = 12'h100;
        num_words = 11'd5;
      end
      out_ready = (k <= v.hold) ? 1'b0 : v.pat[k % 8];
      if (out_valid && out_ready) begin
        check({tag, " word"}, 64'(out_data), 64'(mem_val((v.first_idx + got) % 1024)));
        got++;
        if (got == v.num) last_k = k;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(done_k >= 0), 64'(1));
    check({tag, " word_count"}, 64'(got), 64'(v.num));
    check({tag, " busy_at_done"}, 64'(busy), 64'(0));
    check({tag, " stall_stable"}, 64'(stall_bad), 64'(0));
    check({tag, " no_writes"}, 64'(side_bad), 64'(0));
    if (v.num == 0) begin
      check({tag, " done_next_cycle"}, 64'(done_k), 64'(1));
      check({tag, " never_valid"}, 64'(first_k), 64'(-1));
    end else begin
      check({tag, " done_timing"}, 64'(done_k), 64'(last_k + 1));
      if (v.hold == 0) check({tag, " first_valid"}, 64'(first_k), 64'(3));
      if (v.hold == 0 && v.pat == 8'hFF)
        check({tag, " no_bubbles"}, 64'(last_k - first_k), 64'(v.num - 1));
    end
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'(0));
    check({tag, " idle_after"}, 64'(out_valid), 64'(0));
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int got;
    for (int i = 0; i < 1024; i++) mem[i] = mem_val(i);
    vecs[0] = '{base: 12'h010, num: 4, pat: 8'hFF,        first_idx: 4,    hold: 0,  restart_k: -1};
    vecs[1] = '{base: 12'h010, num: 4, pat: 8'b0100_1001, first_idx: 4,    hold: 0,  restart_k: -1};
    vecs[2] = '{base: 12'h020, num: 8, pat: 8'hFF,        first_idx: 8,    hold: 10, restart_k: -1};
    vecs[3] = '{base: 12'hFF8, num: 4, pat: 8'hFF,        first_idx: 1022, hold: 0,  restart_k: -1};
    vecs[4] = '{base: 12'h000, num: 0, pat: 8'hFF,        first_idx: 0,    hold: 0,  restart_k: -1};
    vecs[5] = '{base: 12'h203, num: 6, pat: 8'b0110_1101, first_idx: 128,  hold: 0,  restart_k: 3};

    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy",      64'(busy),        64'(0));
    check("reset done",      64'(done),        64'(0));
    check("reset bram_addr", 64'(bram_addr),   64'(0));
    check("reset out_valid", 64'(out_valid),   64'(0));
    check("reset out_data",  64'(out_data),    64'(0));
    check("reset bram_we",   64'(bram_we),     64'(0));
    check("reset wrdata",    64'(bram_wrdata), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of a 6-word command after two words are accepted.
    @(negedge clk);
    start = 1'b1; base_addr = 12'h040; num_words = 11'd6; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && got < 2; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        check("midreset word", 64'(out_data), 64'(mem_val(16 + got)));
        got++;
      end
    end
    check("midreset reached", 64'(got), 64'(2));
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("midreset out_valid", 64'(out_valid), 64'(0));
    check("midreset busy",      64'(busy),      64'(0));
    check("midreset bram_addr", 64'(bram_addr), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("postreset stale", 64'(out_valid), 64'(0));
    run_cmd("postreset", '{base: 12'h000, num: 2, pat: 8'hFF, first_idx: 0, hold: 0, restart_k: -1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Sequential read engine that sits directly in front of a `bram` instance and turns a (base address, word count) command into a valid/ready word stream for the downstream compute datapath (x/y vector and weight feeds). It drives the BRAM address port, absorbs the BRAM's fixed 1-cycle read latency, and buffers in-flight words so downstream backpressure never loses data. Writes are never issued.

## Interface

- `BRAM_WIDTH`, default 32: data word width; must equal the connected BRAM's width.
- `ADDR_WIDTH`, default 12: byte-address width of the BRAM port.
- `WORD_SIZE`, default 4: bytes per word; the address step.
- `LEN_WIDTH`, default 11: width of `num_words`; the maximum is 2^LEN_WIDTH−1.

Ports:

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: command strobe; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: byte address of the first word; low log2(WORD_SIZE) bits ignored (treated as 0).
- `num_words` in LEN_WIDTH: words to stream; 0 is legal.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at command completion.
- `bram_addr` out ADDR_WIDTH: registered read address to the BRAM.
- `bram_rddata` in BRAM_WIDTH: BRAM read data, valid one cycle after the address edge.
- `bram_wrdata` out BRAM_WIDTH: constant 0.
- `bram_we` out WORD_SIZE: constant 0.
- `out_data` out BRAM_WIDTH: stream word.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: downstream accept.

## Operation

- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start` with `num_words` ≠ 0: latch `addr`=`base_addr` (aligned) and `remaining`=`num_words`.
  - IDLE with `start` and `num_words`=0: pulse `done` next cycle and stay IDLE; no reads, no stream words.
  - RUN→DRAIN when the last read is issued (`remaining` reaches 0).
  - DRAIN→IDLE on the handshake of the last word.
- Read issue rule:
  - Issue a read in a cycle when in RUN and (fifo_count + inflight) < 4. `inflight` is 1 if a read was issued the previous cycle.
  - On issue: `addr` += WORD_SIZE, modulo 2^ADDR_WIDTH (wrap past the top to 0), and `remaining` −= 1.
- Capture: when `inflight`=1, push `bram_rddata` into the 4-entry FIFO. The issue rule guarantees the push never overflows.
- Stream side:
  - `out_valid` = FIFO not empty; `out_data` = FIFO head.
  - Pop on `out_valid` & `out_ready`.
  - A push and pop in the same cycle leaves the count unchanged.
- Handshake rules: once `out_valid` is high, `out_data` is held stable until accepted. `out_ready` may toggle arbitrarily.
- `start` while `busy` is ignored (no latch, no error).
- Words are delivered in address order, exactly `num_words` of them, with no duplication or loss.
- Reset (any state, including mid-command):
  - Go to IDLE and flush the FIFO; clear `inflight` and `remaining`.
  - A BRAM read already issued is discarded.

## Timing

- Reset values: `busy`=0, `done`=0, `bram_addr`=0, `out_valid`=0, `out_data`=0, `bram_we`=0, `bram_wrdata`=0.
- Latency, with `start` sampled at edge E:
  - `bram_addr`=base after E.
  - BRAM samples at E+1.
  - Word pushed at E+2, so `out_valid` is first high after E+2.
  - Start-to-first-valid is 2 cycles.
- Throughput: with `out_ready` held high, 1 word/cycle sustained with no bubbles after the first.
- `done` goes high in the cycle after the final handshake. `busy` drops in that same cycle.
- A new `start` is accepted in the cycle `done` is high (the FSM is IDLE).
- `bram_addr` holds its last value when not issuing. The BRAM re-reading it is harmless; no capture occurs without `inflight`.

## Structure

- Package `bram_stream_pkg`:
  - state enum `stream_state_t` {IDLE, RUN, DRAIN};
  - localparam `FIFO_DEPTH`=4;
  - issue-threshold constant.
- Sub-module `sync_fifo`, parameterised by width and depth, exposing count, push, pop, and head.
- The top level holds the FSM, the address/remaining counters, and the inflight flag.

## Test plan

- base=0x010, num=4, mem[4..7]=A,B,C,D, `out_ready`=1 → `out_valid` 2 cycles after start; A,B,C,D on consecutive cycles; `done` 1 cycle after D; `bram_we` always 0.
- Same command with `out_ready` toggling 1,0,0,1,… → identical data order, `out_data` stable while stalled, FIFO count never exceeds 4.
- `out_ready`=0 for 10 cycles after start, num=8 → exactly 4 reads issued then `bram_addr` frozen; releasing `out_ready` delivers all 8 words in order.
- base=0xFF8, num=4 → addresses FF8, FFC, 000, 004; words mem[1022], mem[1023], mem[0], mem[1].
- num=0 → `done` pulses next cycle, `busy` stays 0, `out_valid` never asserted. A second `start` asserted mid-command is ignored.
- `reset` asserted after 2 of 6 words are delivered → next cycle `out_valid`=0, `busy`=0, `bram_addr`=0. A following command (base=0, num=2) streams mem[0], mem[1] correctly with no stale data.
